// File: rtl/led_scan_if.sv
// Handshake and display-pin bundle for led_scan_ctrl.
interface led_scan_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
);
    logic [BIN_W-1:0]  bin_in;
    logic              in_valid;
    logic              in_ready;
    logic              done;
    logic              blank_en;
    logic [DIGITS-1:0] dp_in;
    logic [DIGITS-1:0] dig_sel;
    logic [7:0]        seg;

    modport master (
        output bin_in, in_valid, blank_en, dp_in,
        input  in_ready, done, dig_sel, seg
    );

    modport slave (
        input  bin_in, in_valid, blank_en, dp_in,
        output in_ready, done, dig_sel, seg
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// Multiplexed 7-segment controller: binary-to-BCD by repeated subtraction,
// double-buffered digits, and a prescaled digit scan.
module led_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned BIN_W    = 14,
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic     clk,
    input logic     rst_n,
    led_scan_if.slave bus
);
    localparam int unsigned POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    // 10^n for n in 0..8, evaluated in 64 bits so the overflow bound always fits
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3f;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5b;
            4'd3:    s = 7'h4f;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6d;
            4'd6:    s = 7'h7d;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7f;
            4'd9:    s = 7'h6f;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  rem_q, rem_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        work_q [DIGITS];
    logic [3:0]        work_d [DIGITS];
    logic [3:0]        disp_q [DIGITS];
    logic              ovf_pend_q, ovf_pend_d;
    logic              ovf_q;
    logic              done_q, in_ready_q;
    logic [PRE_W-1:0]  pre_q;
    logic [POS_W-1:0]  idx_q;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [7:0]        seg_q, seg_d;

    assign bus.in_ready = in_ready_q;
    assign bus.done     = done_q;
    assign bus.dig_sel  = dig_sel_q;
    assign bus.seg      = seg_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and conversion datapath: one subtract or one digit store per clock
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        ovf_pend_d = ovf_pend_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    rem_d = bus.bin_in;
                    if (64'(bus.bin_in) >= pow10(DIGITS)) begin
                        ovf_pend_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        ovf_pend_d = 1'b0;
                        pos_d      = POS_W'(DIGITS - 1);
                        cnt_d      = 4'd0;
                        state_d    = S_CONV;
                    end
                end
            end
            S_CONV: begin
                if (64'(rem_q) >= pow10(32'(pos_q))) begin
                    rem_d = rem_q - BIN_W'(pow10(32'(pos_q)));
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    work_d[pos_q] = cnt_q;
                    cnt_d         = 4'd0;
                    if (pos_q == '0) state_d = S_DONE;
                    else             pos_d   = pos_q - POS_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Conversion registers; the display buffer commits only on exit from DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= '0;
            pos_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                work_q[i] <= '0;
                disp_q[i] <= '0;
            end
        end else begin
            rem_q      <= rem_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            work_q     <= work_d;
            done_q     <= (state_d == S_DONE);
            in_ready_q <= (state_d == S_IDLE);
            if (state_q == S_DONE) begin
                disp_q <= work_q;
                ovf_q  <= ovf_pend_q;
            end
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == POS_W'(DIGITS - 1)) ? '0 : idx_q + POS_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Segment pattern for the selected digit: dash on overflow, leading-zero blanking
    always_comb begin
        logic       blank;
        logic [6:0] seg7;
        blank = 1'b0;
        if (bus.blank_en && (idx_q != '0)) begin
            blank = 1'b1;
            for (int unsigned j = 0; j < DIGITS; j++) begin
                if ((j >= 32'(idx_q)) && (disp_q[j] != 4'd0)) blank = 1'b0;
            end
        end
        if (ovf_q)      seg7 = 7'h40;
        else if (blank) seg7 = 7'h00;
        else            seg7 = seg_enc(disp_q[idx_q]);
        seg_d     = {bus.dp_in[idx_q], seg7};
        dig_sel_d = ~(DIGITS'(1) << idx_q);
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel_q <= '1;
            seg_q     <= '0;
        end else begin
            dig_sel_q <= dig_sel_d;
            seg_q     <= seg_d;
        end
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with DIGITS=4, BIN_W=14, SCAN_DIV=4.
module tb_led_scan_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    led_scan_if #(.DIGITS(4), .BIN_W(14)) bus ();

    led_scan_ctrl #(.DIGITS(4), .BIN_W(14), .SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] val;
        logic        blank;
        logic [3:0]  dp;
        int          lat;
        logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a value, measure the cycle in which done is seen, then check handshake recovery.
    task automatic send(input logic [13:0] v, input logic noise, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        chk({tag, "_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (noise) bus.bin_in = 14'd1111;
        else       bus.in_valid = 1'b0;
        chk({tag, "_ready_busy"}, 32'(bus.in_ready), 32'd0);
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (noise && lat == 30) bus.in_valid = 1'b0;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Sample seg while each digit is selected
    task automatic check_disp(input logic [31:0] s, input string tag);
        logic [3:0] want;
        int n;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            want = ~(4'b0001 << d);
            n = 0;
            while (bus.dig_sel !== want && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("%s_sel%0d", tag, d), 32'(bus.dig_sel), 32'(want));
            chk($sformatf("%s_seg%0d", tag, d), 32'(bus.seg), 32'(s[d*8 +: 8]));
        end
    endtask

    initial begin
        int n;
        int run;
        int dones;
        total = 0;
        bad   = 0;

        vecs[0] = '{val: 14'd1234,  blank: 1'b0, dp: 4'b0000, lat: 15, segs: 32'h065b4f66};
        vecs[1] = '{val: 14'd9999,  blank: 1'b0, dp: 4'b0000, lat: 41, segs: 32'h6f6f6f6f};
        vecs[2] = '{val: 14'd7,     blank: 1'b1, dp: 4'b0000, lat: 12, segs: 32'h00000007};
        vecs[3] = '{val: 14'd0,     blank: 1'b1, dp: 4'b0001, lat: 5,  segs: 32'h000000bf};
        vecs[4] = '{val: 14'd10000, blank: 1'b0, dp: 4'b0000, lat: 1,  segs: 32'h40404040};
        vecs[5] = '{val: 14'd5,     blank: 1'b0, dp: 4'b0000, lat: 10, segs: 32'h3f3f3f6d};
        vecs[6] = '{val: 14'd1020,  blank: 1'b1, dp: 4'b0000, lat: 8,  segs: 32'h063f5b3f};
        vecs[7] = '{val: 14'd16383, blank: 1'b0, dp: 4'b1010, lat: 1,  segs: 32'hc040c040};

        rst_n        = 1'b0;
        bus.bin_in   = '0;
        bus.in_valid = 1'b0;
        bus.blank_en = 1'b0;
        bus.dp_in    = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dig_sel", 32'(bus.dig_sel), 32'hf);
        chk("rst_seg", 32'(bus.seg), 32'h0);
        rst_n = 1'b1;

        // Scan walk: each digit held for 4 clocks
        n = 0;
        while (bus.dig_sel !== 4'b1101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("walk_reach", 32'(bus.dig_sel), 32'hd);
        run = 0;
        while (bus.dig_sel === 4'b1101 && run < 20) begin
            run++;
            @(negedge clk);
        end
        chk("walk_len", 32'(run), 32'd4);
        chk("walk_next", 32'(bus.dig_sel), 32'hb);
        check_disp(32'h3f3f3f3f, "rst_disp");

        // Table of values
        for (int i = 0; i < 8; i++) begin
            bus.blank_en = vecs[i].blank;
            bus.dp_in    = vecs[i].dp;
            send(vecs[i].val, 1'b0, vecs[i].lat, $sformatf("v%0d", i));
            check_disp(vecs[i].segs, $sformatf("v%0d_disp", i));
        end

        // in_valid with a different value while busy must be ignored
        bus.blank_en = 1'b0;
        bus.dp_in    = '0;
        send(14'd9999, 1'b1, 41, "noise");
        check_disp(32'h6f6f6f6f, "noise_disp");

        // Reset in the middle of a conversion
        @(negedge clk);
        bus.bin_in   = 14'd9999;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_dig_sel", 32'(bus.dig_sel), 32'hf);
        chk("mid_rst_seg", 32'(bus.seg), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("mid_rst_no_done", 32'(dones), 32'd0);
        check_disp(32'h3f3f3f3f, "mid_rst_disp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
